// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MAX_FLUSH_DEPTH = 4;

endpackage

// File: rtl/hazard_stall_counter.sv
// Purpose: loadable down-counter shared by the MULTI and FLUSH states.
// Latency: load/decrement take effect on the next rising edge; flags are combinational.
// Backpressure: none; the count holds at zero instead of wrapping.
module hazard_stall_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_one,
    output logic             is_zero
);

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one  = (count == {{(CNT_W-1){1'b0}}, 1'b1});
    assign is_zero = (count == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush sequencer for load-use, taken branch/jump and multi-cycle EX hazards.
// Latency: control outputs are combinational (same-cycle); state/counter update on the rising edge.
// Backpressure: holds PC and IF/ID for load-use and multi-cycle ops; HAZARD_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W          = 6,
    parameter int BR_FLUSH_DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_branch_taken,
    input  logic             i_ex_jump,
    input  logic             i_id_multi,
    input  logic [CNT_W-1:0] i_id_multi_cycles,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_busy,
    output logic [1:0]       o_state,
    output logic [31:0]      o_stall_count,
    output logic [31:0]      o_flush_count
);

    // Out-of-range depths are clamped into 1..MAX_FLUSH_DEPTH.
    localparam int FLUSH_DEPTH = (BR_FLUSH_DEPTH < 1) ? 1 :
                                 (BR_FLUSH_DEPTH > MAX_FLUSH_DEPTH) ? MAX_FLUSH_DEPTH :
                                 BR_FLUSH_DEPTH;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);

    state_t           state, state_next;
    logic             cnt_load, cnt_dec, cnt_is_one, cnt_is_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt_value;
    logic             taken, load_use, multi_long;

    assign taken      = i_ex_branch_taken | i_ex_jump;
    assign load_use   = i_ex_mem_read && (i_ex_rt != REG_ZERO) &&
                        ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    assign multi_long = i_id_multi && (i_id_multi_cycles >= CNT_W'(2));

    hazard_stall_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (i_clk),
        .reset    (i_reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .is_one   (cnt_is_one),
        .is_zero  (cnt_is_zero)
    );

    // State register; reset aborts any MULTI/FLUSH sequence.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control; taken beats load-use beats multi.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            RUN: begin
                if (taken) begin
                    if (FLUSH_DEPTH > 1) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = FLUSH_LOAD;
                        state_next   = FLUSH;
                    end
                end else if (load_use) begin
                    state_next = RUN;
                end else if (multi_long) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = i_id_multi_cycles - 1'b1;
                    state_next   = MULTI;
                end
            end
            MULTI, FLUSH: begin
                cnt_dec = 1'b1;
                // Zero is unreachable in normal flow; leaving on it avoids a stuck state.
                if (cnt_is_one || cnt_is_zero) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Mealy control outputs; reset forces a frozen, flushed front end.
    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        if (i_reset) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (taken) begin
                        o_if_id_flush  = 1'b1;
                        o_id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        o_pc_write     = 1'b0;
                        o_if_id_write  = 1'b0;
                        o_id_ex_bubble = 1'b1;
                    end
                end
                MULTI: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                end
                FLUSH: begin
                    o_if_id_flush  = 1'b1;
                    o_id_ex_bubble = 1'b1;
                end
                default: begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign o_state = i_reset ? RUN : state;
    assign o_busy  = !i_reset && (state != RUN);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;

    // Stall cycles and RUN-state taken events; both wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (!o_pc_write) begin
                stall_count <= stall_count + 32'd1;
            end
            if ((state == RUN) && taken) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    assign o_stall_count = stall_count;
    assign o_flush_count = flush_count;
`else
    assign o_stall_count = 32'd0;
    assign o_flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_jump, id_multi;
    logic [5:0] id_multi_cycles;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_busy;
    logic [1:0]  a_state;
    logic [31:0] a_stall_count, a_flush_count;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_busy;
    logic [1:0]  b_state;
    logic [31:0] b_stall_count, b_flush_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(6), .BR_FLUSH_DEPTH(1)) dut_d1 (
        .i_clk(clk), .i_reset(reset),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
        .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
        .i_ex_branch_taken(ex_branch_taken), .i_ex_jump(ex_jump),
        .i_id_multi(id_multi), .i_id_multi_cycles(id_multi_cycles),
        .o_pc_write(a_pc_write), .o_if_id_write(a_if_id_write),
        .o_if_id_flush(a_if_id_flush), .o_id_ex_bubble(a_id_ex_bubble),
        .o_busy(a_busy), .o_state(a_state),
        .o_stall_count(a_stall_count), .o_flush_count(a_flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_W(6), .BR_FLUSH_DEPTH(3)) dut_d3 (
        .i_clk(clk), .i_reset(reset),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
        .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
        .i_ex_branch_taken(ex_branch_taken), .i_ex_jump(ex_jump),
        .i_id_multi(id_multi), .i_id_multi_cycles(id_multi_cycles),
        .o_pc_write(b_pc_write), .o_if_id_write(b_if_id_write),
        .o_if_id_flush(b_if_id_flush), .o_id_ex_bubble(b_id_ex_bubble),
        .o_busy(b_busy), .o_state(b_state),
        .o_stall_count(b_stall_count), .o_flush_count(b_flush_count)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble} plus busy and state
    wire [6:0] a_obs = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_busy, a_state};
    wire [6:0] b_obs = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_busy, b_state};

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0;
        id_multi = 1'b0; id_multi_cycles = 6'd0;
    endtask

    // Inputs change 1 time unit after the edge; outputs sampled 3 units later.
    task automatic settle();
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        ex_branch_taken = 1'b1;
        next_cycle();
        settle();
        total++;
        if (a_obs !== 7'b0011_0_00) $display("FAIL reset_forced got=%b exp=%b", a_obs, 7'b0011_0_00);
        else passed++;
        total++;
        if (a_stall_count !== 32'd0 || a_flush_count !== 32'd0)
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", a_stall_count, a_flush_count);
        else passed++;
        next_cycle();
        reset = 1'b0;
        idle();
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL reset_release got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        settle();
        total++;
        if (a_obs !== 7'b0001_0_00) $display("FAIL load_use_rs got=%b exp=%b", a_obs, 7'b0001_0_00);
        else passed++;
        next_cycle();
        idle();
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL load_use_after got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL load_use_r0 got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        idle();
    endtask

    task automatic test_rt_dependence();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL rt_unused got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        id_uses_rt = 1'b1;
        settle();
        total++;
        if (a_obs !== 7'b0001_0_00) $display("FAIL rt_used got=%b exp=%b", a_obs, 7'b0001_0_00);
        else passed++;
        next_cycle();
        idle();
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL rt_after got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
    endtask

    task automatic test_multi();
        pulse_reset();
        id_multi = 1'b1; id_multi_cycles = 6'd5;
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL multi_issue got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (a_obs !== 7'b0001_1_01) $display("FAIL multi_hold%0d got=%b exp=%b", i, a_obs, 7'b0001_1_01);
            else passed++;
            next_cycle();
        end
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL multi_done got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        id_multi = 1'b1; id_multi_cycles = 6'd1;
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL multi_n1_issue got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        idle();
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL multi_n1_next got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
    endtask

    task automatic test_branch_vs_load_use();
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        id_multi = 1'b1; id_multi_cycles = 6'd5;
        settle();
        total++;
        if (a_obs !== 7'b1111_0_00) $display("FAIL branch_prio got=%b exp=%b", a_obs, 7'b1111_0_00);
        else passed++;
        next_cycle();
        idle();
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL branch_next got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (a_stall_count !== 32'd4 || a_flush_count !== 32'd1)
            $display("FAIL perf_counts got=%0d/%0d exp=4/1", a_stall_count, a_flush_count);
        else passed++;
`else
        total++;
        if (a_stall_count !== 32'd0 || a_flush_count !== 32'd0)
            $display("FAIL perf_tied got=%0d/%0d exp=0/0", a_stall_count, a_flush_count);
        else passed++;
`endif
        next_cycle();
    endtask

    task automatic test_flush_depth3();
        pulse_reset();
        ex_jump = 1'b1;
        settle();
        total++;
        if (b_obs !== 7'b1111_0_00) $display("FAIL flush3_c1 got=%b exp=%b", b_obs, 7'b1111_0_00);
        else passed++;
        next_cycle();
        // Hazard inputs present during FLUSH must be ignored.
        ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; ex_jump = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (b_obs !== 7'b1111_1_10) $display("FAIL flush3_c%0d got=%b exp=%b", i + 2, b_obs, 7'b1111_1_10);
            else passed++;
            next_cycle();
        end
        idle();
        settle();
        total++;
        if (b_obs !== 7'b1100_0_00) $display("FAIL flush3_done got=%b exp=%b", b_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid_multi();
        id_multi = 1'b1; id_multi_cycles = 6'd6;
        settle();
        total++;
        if (a_obs !== 7'b1100_0_00) $display("FAIL rmm_issue got=%b exp=%b", a_obs, 7'b1100_0_00);
        else passed++;
        next_cycle();
        idle();
        settle();
        total++;
        if (a_obs !== 7'b0001_1_01) $display("FAIL rmm_hold1 got=%b exp=%b", a_obs, 7'b0001_1_01);
        else passed++;
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (a_obs !== 7'b0011_0_00) $display("FAIL rmm_forced%0d got=%b exp=%b", i, a_obs, 7'b0011_0_00);
            else passed++;
            next_cycle();
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (a_obs !== 7'b1100_0_00) $display("FAIL rmm_run%0d got=%b exp=%b", i, a_obs, 7'b1100_0_00);
            else passed++;
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_rt_dependence();
        test_multi();
        test_branch_vs_load_use();
        test_flush_depth3();
        test_reset_mid_multi();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
